// File: rtl/window_pkg.sv
// Shared definitions for the 5x5 window frame sequencer.
// Holds the sequencer FSM encoding, the default border size, the flush length helper
// and the pixel type used on both the upstream stream and the window datapath.
package window_pkg;

    typedef logic [7:0] pixel_t;

    // Sequencer FSM encoding
    localparam logic [1:0] ST_CLEAR  = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;
    localparam logic [1:0] ST_FLUSH  = 2'd3;

    localparam int BORDER_DEFAULT = 2;

    // Zero pixels needed to push the last real pixel through the x-window,
    // the five-row array and the y-window.
    function automatic int flush_len(input int width);
        return 3 * width + 12;
    endfunction

endpackage

// File: rtl/window_raster_counter.sv
// Raster position tracker: x/y counters with wrap, last-pixel flag and border flag.
// Latency: counters and border flag update on the edge after advance; last is combinational.
// Backpressure: none; advances only when the parent accepts a pixel.
// Ports: clock/reset (sync, active-high), clear (return to origin), advance (pixel accepted),
//        last (current position is the final pixel), on_border (current position lies in the border),
//        at_origin (current position is (0,0); present only with WINDOW_SEQ_ERR_EN).
module window_raster_counter #(
    parameter int WIDTH  = 420,
    parameter int HEIGHT = 315,
    parameter int BORDER = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic advance,
    output logic last,
`ifdef WINDOW_SEQ_ERR_EN
    output logic at_origin,
`endif
    output logic on_border
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);

    localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);
    localparam logic [XW-1:0] X_LO  = XW'(BORDER);
    localparam logic [XW-1:0] X_HI  = XW'(WIDTH - BORDER);
    localparam logic [YW-1:0] Y_LO  = YW'(BORDER);
    localparam logic [YW-1:0] Y_HI  = YW'(HEIGHT - BORDER);

    logic [XW-1:0] x, x_nxt;
    logic [YW-1:0] y, y_nxt;
    logic          border_q;

    function automatic logic is_border(input logic [XW-1:0] px, input logic [YW-1:0] py);
        return (px < X_LO) || (px >= X_HI) || (py < Y_LO) || (py >= Y_HI);
    endfunction

    // Advance has priority over clear: the start-of-frame pixel is accepted
    // while the parent is still idle and must step the raster off (0,0).
    always_comb begin
        x_nxt = x;
        y_nxt = y;
        if (advance) begin
            if (x == X_MAX) begin
                x_nxt = '0;
                y_nxt = (y == Y_MAX) ? '0 : y + 1'b1;
            end else begin
                x_nxt = x + 1'b1;
            end
        end else if (clear) begin
            x_nxt = '0;
            y_nxt = '0;
        end
    end

    // The border flag is computed from the next position so that it is a
    // register describing the pixel that will be accepted next.
    always_ff @(posedge clock) begin
        if (reset) begin
            x        <= '0;
            y        <= '0;
            border_q <= is_border(XW'(0), YW'(0));
        end else begin
            x        <= x_nxt;
            y        <= y_nxt;
            border_q <= is_border(x_nxt, y_nxt);
        end
    end

    assign last      = (x == X_MAX) && (y == Y_MAX);
    assign on_border = border_q;
`ifdef WINDOW_SEQ_ERR_EN
    assign at_origin = (x == '0) && (y == '0);
`endif

endmodule

// File: rtl/window_frame_sequencer.sv
// Frame sequencer feeding one frame of pixels into the 5x5 window datapath, blanking the border and flushing with zeros.
// Latency: win_* outputs registered, one cycle after pixel acceptance.
// Backpressure: in_ready is low in CLEAR and FLUSH (and during reset); upstream must hold its pixel.
// Ports: clock/reset (sync, active-high); in_data/in_sof/in_valid/in_ready upstream handshake;
//        win_din/win_validin/win_blanking/win_clear drive the window datapath; busy, frame_done status;
//        err_status sticky {len_err, sof_err}, present only when WINDOW_SEQ_ERR_EN is defined.
module window_frame_sequencer
    import window_pkg::*;
#(
    parameter int WIDTH     = 420,
    parameter int HEIGHT    = 315,
    parameter int BORDER    = BORDER_DEFAULT,
    parameter int FLUSH_LEN = flush_len(WIDTH)
) (
    input  logic       clock,
    input  logic       reset,
    input  pixel_t     in_data,
    input  logic       in_sof,
    input  logic       in_valid,
    output logic       in_ready,
    output pixel_t     win_din,
    output logic       win_validin,
    output logic       win_blanking,
    output logic       win_clear,
    output logic       busy,
`ifdef WINDOW_SEQ_ERR_EN
    output logic [1:0] err_status,
`endif
    output logic       frame_done
);

    localparam int FW = $clog2(FLUSH_LEN + 1);
    localparam logic [FW-1:0] FLUSH_MAX = FW'(FLUSH_LEN);

    logic [1:0]    state;
    logic [FW-1:0] flush_cnt;
    logic          accept;
    logic          rc_advance;
    logic          rc_clear;
    logic          rc_last;
    logic          rc_border;
`ifdef WINDOW_SEQ_ERR_EN
    logic          rc_origin;
`endif

    assign in_ready  = ~reset & ((state == ST_IDLE) | (state == ST_ACTIVE));
    assign accept    = in_valid & in_ready;
    assign win_clear = reset | (state == ST_CLEAR);
    assign busy      = (state == ST_ACTIVE) | (state == ST_FLUSH);

    // In IDLE only a start-of-frame pixel moves the raster; anything else
    // keeps it parked at the origin.
    assign rc_advance = accept & ((state == ST_ACTIVE) | in_sof);
    assign rc_clear   = (state != ST_ACTIVE);

    window_raster_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .BORDER (BORDER)
    ) u_raster (
        .clock     (clock),
        .reset     (reset),
        .clear     (rc_clear),
        .advance   (rc_advance),
        .last      (rc_last),
`ifdef WINDOW_SEQ_ERR_EN
        .at_origin (rc_origin),
`endif
        .on_border (rc_border)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_CLEAR;
            flush_cnt    <= '0;
            win_din      <= '0;
            win_validin  <= 1'b0;
            win_blanking <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            win_validin <= 1'b0;
            frame_done  <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    flush_cnt <= '0;
                    state     <= ST_IDLE;
                end
                ST_IDLE: begin
                    // Non-SOF pixels are drained and dropped while waiting for a frame.
                    if (accept && in_sof) begin
                        win_din      <= in_data;
                        win_validin  <= 1'b1;
                        win_blanking <= rc_border;
                        state        <= rc_last ? ST_FLUSH : ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    // A stray SOF here is ordinary data; the frame is not restarted.
                    if (accept) begin
                        win_din      <= in_data;
                        win_validin  <= 1'b1;
                        win_blanking <= rc_border;
                        if (rc_last) begin
                            state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    // FLUSH_LEN zero pixels, then one frame_done cycle, then CLEAR.
                    // frame_done itself marks that the pulse has been issued.
                    if (flush_cnt != FLUSH_MAX) begin
                        win_din      <= '0;
                        win_validin  <= 1'b1;
                        win_blanking <= 1'b1;
                        flush_cnt    <= flush_cnt + 1'b1;
                    end else if (!frame_done) begin
                        frame_done <= 1'b1;
                    end else begin
                        state <= ST_CLEAR;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

`ifdef WINDOW_SEQ_ERR_EN
    // Sticky diagnostics; they never alter the datapath sequence.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_status <= 2'b00;
        end else if (accept && (state == ST_ACTIVE) && in_sof) begin
            if (!rc_origin) begin
                err_status[0] <= 1'b1;
            end
            if (rc_last) begin
                err_status[1] <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_window_frame_sequencer.sv
// Bench for window_frame_sequencer at WIDTH=8, HEIGHT=6, FLUSH_LEN=36.
// Stimulus pushes expected window events into a scoreboard queue; a negedge monitor pops and compares.
// Covers reset state, SOF hunting, border blanking, flush/done/clear ordering, stalls, mid-frame reset, stray SOF.
module tb_window_frame_sequencer;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int FL = 36;

    localparam logic [1:0] K_PIX   = 2'd0;
    localparam logic [1:0] K_FLUSH = 2'd1;
    localparam logic [1:0] K_DONE  = 2'd2;
    localparam logic [1:0] K_CLR   = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] din;
        logic       blank;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_sof;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] win_din;
    logic       win_validin;
    logic       win_blanking;
    logic       win_clear;
    logic       busy;
    logic       frame_done;
`ifdef WINDOW_SEQ_ERR_EN
    logic [1:0] err_status;
`endif

    always #5 clock = ~clock;

    window_frame_sequencer #(
        .WIDTH     (W),
        .HEIGHT    (H),
        .BORDER    (2),
        .FLUSH_LEN (FL)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .in_data      (in_data),
        .in_sof       (in_sof),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .win_din      (win_din),
        .win_validin  (win_validin),
        .win_blanking (win_blanking),
        .win_clear    (win_clear),
        .busy         (busy),
`ifdef WINDOW_SEQ_ERR_EN
        .err_status   (err_status),
`endif
        .frame_done   (frame_done)
    );

    exp_t sbq[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   unblanked = 0;

    // Reference raster model
    bit   m_act;
    int   mx, my;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit bord(input int x, input int y);
        return (x < 2) || (x >= W - 2) || (y < 2) || (y >= H - 2);
    endfunction

    task automatic push(input logic [1:0] k, input logic [7:0] d, input logic b);
        exp_t e;
        e.kind  = k;
        e.din   = d;
        e.blank = b;
        sbq.push_back(e);
    endtask

    task automatic model_accept(input logic [7:0] d, input bit sof);
        if (!m_act) begin
            if (!sof) return;
            m_act = 1'b1;
            mx = 0;
            my = 0;
        end
        push(K_PIX, d, bord(mx, my));
        mx++;
        if (mx == W) begin
            mx = 0;
            my++;
        end
        if (my == H) begin
            for (int i = 0; i < FL; i++) push(K_FLUSH, 8'd0, 1'b1);
            push(K_DONE, 8'd0, 1'b0);
            push(K_CLR, 8'd0, 1'b0);
            m_act = 1'b0;
        end
    endtask

    // Monitor: every window event must match the head of the scoreboard.
    always @(negedge clock) begin
        if (!reset) begin
            if (win_validin) begin
                chk("sb_has_pixel", sbq.size() > 0, 1);
                if (sbq.size() > 0) begin
                    mon_e = sbq.pop_front();
                    chk("pix_kind_is_data", mon_e.kind == K_PIX || mon_e.kind == K_FLUSH, 1);
                    chk("win_din", win_din, mon_e.din);
                    chk("win_blanking", win_blanking, mon_e.blank);
                    chk("busy_on_pixel", busy, 1);
                    if (mon_e.kind == K_FLUSH) chk("in_ready_flush", in_ready, 0);
                    if (mon_e.kind == K_PIX && !win_blanking) unblanked++;
                end
            end
            if (frame_done) begin
                chk("sb_has_done", sbq.size() > 0, 1);
                if (sbq.size() > 0) begin
                    mon_e = sbq.pop_front();
                    chk("done_kind", mon_e.kind, K_DONE);
                end
            end
            if (win_clear) begin
                chk("sb_has_clear", sbq.size() > 0, 1);
                if (sbq.size() > 0) begin
                    mon_e = sbq.pop_front();
                    chk("clear_kind", mon_e.kind, K_CLR);
                    chk("in_ready_clear", in_ready, 0);
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_validin", win_validin, 0);
        chk("rst_din", win_din, 0);
        chk("rst_blanking", win_blanking, 0);
        chk("rst_clear", win_clear, 1);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
`ifdef WINDOW_SEQ_ERR_EN
        chk("rst_err", err_status, 0);
`endif
        sbq.delete();
        m_act = 1'b0;
        push(K_CLR, 8'd0, 1'b0);
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic send_pixel(input logic [7:0] d, input bit sof);
        int t;
        t = 0;
        in_data  = d;
        in_sof   = sof;
        in_valid = 1'b1;
        @(negedge clock);
        while (!in_ready && t < 200) begin
            t++;
            @(negedge clock);
        end
        chk("in_ready_wait", in_ready, 1);
        if (in_ready) model_accept(d, sof);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 500) begin
            t++;
            @(negedge clock);
        end
        chk("drain_empty", sbq.size(), 0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        in_data  = 8'd0;
        in_sof   = 1'b0;
        in_valid = 1'b0;
        m_act    = 1'b0;

        // Reset, single clear cycle, then ready with no window traffic
        do_reset();
        drain();
        @(negedge clock);
        chk("idle_ready", in_ready, 1);
        chk("idle_no_validin", win_validin, 0);
        @(posedge clock);
        #1;

        // Three pre-SOF pixels are discarded, then a full frame
        for (int i = 0; i < 3; i++) send_pixel(8'(200 + i), 1'b0);
        for (int i = 1; i <= W * H; i++) send_pixel(8'(i), i == 1);
        drain();
        chk("unblanked_count", unblanked, 8);

        // Alternating in_valid: stalls must not advance the window
        for (int i = 1; i <= W * H; i++) begin
            send_pixel(8'(100 + i), i == 1);
            @(posedge clock);
            #1;
        end
        drain();

        // Reset mid-frame, then a clean frame from (0,0)
        for (int i = 1; i < 20; i++) send_pixel(8'(i), i == 1);
        do_reset();
        drain();
        for (int i = 1; i <= W * H; i++) send_pixel(8'(50 + i), i == 1);
        drain();

        // Stray SOF at pixel 10 is ordinary data
        for (int i = 1; i <= W * H; i++) send_pixel(8'(150 + i), (i == 1) || (i == 10));
        drain();
`ifdef WINDOW_SEQ_ERR_EN
        chk("err_status_sof", err_status, 2'b01);
`endif
        chk("final_sb_empty", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
